// File: rtl/cdb_arbiter.sv
// ---------------------------------------------------------------------------
// cdb_arbiter
//
// Result buffer and arbiter for the common data bus (CDB). Every functional
// unit (0 alu, 1 mul, 2 div, 3 mem) writes its finished result into a small
// FIFO of its own. One result per cycle is granted by round-robin and
// broadcast on the registered BCEN/BCdata/BClabel bus. Units never wait for
// bus acceptance. They only see src_ready, which depends on FIFO occupancy.
// A result whose label is 0 has no consumer. It is dropped at the FIFO head
// without using a bus slot.
//
// Optional build macro:
//   CDB_BYPASS_EN - a push into an empty FIFO enters arbitration in the same
//                   cycle. If it wins, it is broadcast after that edge and is
//                   never written into the FIFO.
//
// Ports:
//   clk        in   system clock, rising edge
//   RST        in   synchronous reset, active-high
//   src_valid  in   [NUM_SRC]          per-source result valid
//   src_ready  out  [NUM_SRC]          per-source FIFO can accept
//   src_data   in   [NUM_SRC*DATA_W]   packed results, source i at [i*DATA_W +: DATA_W]
//   src_label  in   [NUM_SRC*LABEL_W]  packed tags, source i at [i*LABEL_W +: LABEL_W]
//   BCEN       out  broadcast valid (one cycle per grant)
//   BCdata     out  [DATA_W]   broadcast result
//   BClabel    out  [LABEL_W]  broadcast tag
//   pending    out  total entries held across all FIFOs (registered)
// ---------------------------------------------------------------------------
module cdb_arbiter #(
    parameter int NUM_SRC = 4,
    parameter int DEPTH   = 2,
    parameter int DATA_W  = 32,
    parameter int LABEL_W = 4
) (
    input  logic                                clk,
    input  logic                                RST,
    input  logic [NUM_SRC-1:0]                  src_valid,
    output logic [NUM_SRC-1:0]                  src_ready,
    input  logic [NUM_SRC*DATA_W-1:0]           src_data,
    input  logic [NUM_SRC*LABEL_W-1:0]          src_label,
    output logic                                BCEN,
    output logic [DATA_W-1:0]                   BCdata,
    output logic [LABEL_W-1:0]                  BClabel,
    output logic [$clog2(NUM_SRC*DEPTH+1)-1:0]  pending
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int SRC_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int SCAN_W = SRC_W + 1;
    localparam int PEND_W = $clog2(NUM_SRC*DEPTH + 1);

    // Per-source head view presented to the arbiter
    logic [NUM_SRC-1:0]              headVld_p0;
    logic [NUM_SRC-1:0][DATA_W-1:0]  headData_p0;
    logic [NUM_SRC-1:0][LABEL_W-1:0] headLabel_p0;
    logic [NUM_SRC-1:0]              candidate_p0;
    logic [NUM_SRC-1:0]              zeroDrop_p0;
    logic [NUM_SRC-1:0]              bypassHit;
    logic [NUM_SRC-1:0]              popSel;
    logic [NUM_SRC-1:0][CNT_W-1:0]   countNextAll;

    // Arbitration result
    logic                            grantVld_p0;
    logic [SRC_W-1:0]                grantIdx_p0;
    logic [SRC_W-1:0]                rrPtr;
    logic [SRC_W-1:0]                rrNext;
    logic [SCAN_W-1:0]               scanSum;
    logic [SRC_W-1:0]                scanIdx;
    logic [PEND_W-1:0]               pendingNext;

    // ---- stage p0: per-source FIFOs and head selection ----
    for (genvar g = 0; g < NUM_SRC; g++) begin : gSrc
        logic [DATA_W-1:0]  memData  [DEPTH];
        logic [LABEL_W-1:0] memLabel [DEPTH];
        logic [PTR_W-1:0]   rdPtr;
        logic [PTR_W-1:0]   wrPtr;
        logic [CNT_W-1:0]   count;
        logic [CNT_W-1:0]   countNext;
        logic               isEmpty;
        logic               storePush;
        logic               fifoPop;
        logic [DATA_W-1:0]  inData;
        logic [LABEL_W-1:0] inLabel;

        assign inData  = src_data[g*DATA_W +: DATA_W];
        assign inLabel = src_label[g*LABEL_W +: LABEL_W];
        assign isEmpty = (count == '0);

        // Ready looks only at occupancy, never at a same-cycle pop, so the
        // unit-facing handshake has no path through the arbiter.
        assign src_ready[g] = (count != CNT_W'(DEPTH)) && !RST;

`ifdef CDB_BYPASS_EN
        assign bypassHit[g] = isEmpty && src_valid[g] && src_ready[g];
`else
        assign bypassHit[g] = 1'b0;
`endif

        assign headVld_p0[g]   = !isEmpty || bypassHit[g];
        assign headData_p0[g]  = bypassHit[g] ? inData  : memData[rdPtr];
        assign headLabel_p0[g] = bypassHit[g] ? inLabel : memLabel[rdPtr];
        assign candidate_p0[g] = headVld_p0[g] && (headLabel_p0[g] != '0);
        assign zeroDrop_p0[g]  = headVld_p0[g] && (headLabel_p0[g] == '0);

        assign popSel[g] = zeroDrop_p0[g] ||
                           (grantVld_p0 && (grantIdx_p0 == SRC_W'(g)));

        // A bypassed entry that is consumed right away never occupies a slot.
        assign storePush = src_valid[g] && src_ready[g] && !(bypassHit[g] && popSel[g]);
        assign fifoPop   = popSel[g] && !bypassHit[g];

        always_comb begin
            countNext = count;
            if (storePush && !fifoPop) begin
                countNext = count + CNT_W'(1);
            end else if (!storePush && fifoPop) begin
                countNext = count - CNT_W'(1);
            end
        end

        assign countNextAll[g] = countNext;

        always_ff @(posedge clk) begin
            if (RST) begin
                rdPtr <= '0;
                wrPtr <= '0;
                count <= '0;
            end else begin
                if (storePush) begin
                    wrPtr <= wrPtr + PTR_W'(1);
                end
                if (fifoPop) begin
                    rdPtr <= rdPtr + PTR_W'(1);
                end
                count <= countNext;
            end
        end

        // Payload storage carries no reset; validity lives in count.
        always_ff @(posedge clk) begin
            if (storePush) begin
                memData[wrPtr]  <= inData;
                memLabel[wrPtr] <= inLabel;
            end
        end
    end

    // Round-robin search starting at rrPtr, wrapping modulo NUM_SRC.
    always_comb begin
        grantVld_p0 = 1'b0;
        grantIdx_p0 = '0;
        scanSum     = '0;
        scanIdx     = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            scanSum = {1'b0, rrPtr} + SCAN_W'(k);
            if (scanSum >= SCAN_W'(NUM_SRC)) begin
                scanSum = scanSum - SCAN_W'(NUM_SRC);
            end
            scanIdx = scanSum[SRC_W-1:0];
            if (!grantVld_p0 && candidate_p0[scanIdx]) begin
                grantVld_p0 = 1'b1;
                grantIdx_p0 = scanIdx;
            end
        end
    end

    always_comb begin
        rrNext = grantIdx_p0 + SRC_W'(1);
        if (grantIdx_p0 == SRC_W'(NUM_SRC - 1)) begin
            rrNext = '0;
        end
    end

    always_comb begin
        pendingNext = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            pendingNext = pendingNext + PEND_W'(countNextAll[i]);
        end
    end

    // ---- stage p1: registered broadcast ----
    always_ff @(posedge clk) begin
        if (RST) begin
            rrPtr   <= '0;
            BCEN    <= 1'b0;
            BCdata  <= '0;
            BClabel <= '0;
            pending <= '0;
        end else begin
            pending <= pendingNext;
            BCEN    <= grantVld_p0;
            if (grantVld_p0) begin
                BCdata  <= headData_p0[grantIdx_p0];
                BClabel <= headLabel_p0[grantIdx_p0];
                rrPtr   <= rrNext;
            end else begin
                BCdata  <= '0;
                BClabel <= '0;
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cdb_arbiter
//
// Self-checking bench for cdb_arbiter. A queue-based reference model of the
// arbiter is advanced once per clock edge and supplies expected broadcast,
// pending and ready values. Directed scenarios also check fixed values.
// ---------------------------------------------------------------------------
module tb_cdb_arbiter;

    localparam int NUM_SRC = 4;
    localparam int DEPTH   = 2;
    localparam int DATA_W  = 32;
    localparam int LABEL_W = 4;
    localparam int PEND_W  = $clog2(NUM_SRC*DEPTH + 1);
`ifdef CDB_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    logic                         clk = 1'b0;
    logic                         rst = 1'b1;
    logic [NUM_SRC-1:0]           srcValid = '0;
    logic [NUM_SRC*DATA_W-1:0]    srcData  = '0;
    logic [NUM_SRC*LABEL_W-1:0]   srcLabel = '0;
    logic [NUM_SRC-1:0]           srcReady;
    logic                         bcen;
    logic [DATA_W-1:0]            bcData;
    logic [LABEL_W-1:0]           bcLabel;
    logic [PEND_W-1:0]            pendingOut;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [DATA_W-1:0]  mData  [NUM_SRC][$];
    logic [LABEL_W-1:0] mLabel [NUM_SRC][$];
    int                 mRr = 0;
    logic               expBcen = 1'b0;
    logic [DATA_W-1:0]  expData = '0;
    logic [LABEL_W-1:0] expLabel = '0;
    int                 expPending = 0;
    bit                 mAcc [NUM_SRC];

    cdb_arbiter #(
        .NUM_SRC (NUM_SRC),
        .DEPTH   (DEPTH),
        .DATA_W  (DATA_W),
        .LABEL_W (LABEL_W)
    ) dut (
        .clk       (clk),
        .RST       (rst),
        .src_valid (srcValid),
        .src_ready (srcReady),
        .src_data  (srcData),
        .src_label (srcLabel),
        .BCEN      (bcen),
        .BCdata    (bcData),
        .BClabel   (bcLabel),
        .pending   (pendingOut)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance the reference model across one edge using the current inputs.
    task automatic model_edge();
        bit                 hasHead [NUM_SRC];
        bit                 byp     [NUM_SRC];
        bit                 store   [NUM_SRC];
        logic [LABEL_W-1:0] hl      [NUM_SRC];
        logic [DATA_W-1:0]  hd      [NUM_SRC];
        int                 win;
        int                 s;
        if (rst) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                mData[i].delete();
                mLabel[i].delete();
                mAcc[i] = 1'b0;
            end
            mRr = 0; expBcen = 1'b0; expData = '0; expLabel = '0; expPending = 0;
            return;
        end
        for (int i = 0; i < NUM_SRC; i++) begin
            mAcc[i]    = srcValid[i] && (mLabel[i].size() < DEPTH);
            store[i]   = mAcc[i];
            byp[i]     = 1'b0;
            hasHead[i] = (mLabel[i].size() > 0);
            hl[i]      = hasHead[i] ? mLabel[i][0] : '0;
            hd[i]      = hasHead[i] ? mData[i][0]  : '0;
`ifdef CDB_BYPASS_EN
            if (!hasHead[i] && mAcc[i]) begin
                hasHead[i] = 1'b1;
                byp[i]     = 1'b1;
                hl[i]      = srcLabel[i*LABEL_W +: LABEL_W];
                hd[i]      = srcData[i*DATA_W +: DATA_W];
            end
`endif
        end
        win = -1;
        for (int k = 0; k < NUM_SRC; k++) begin
            s = (mRr + k) % NUM_SRC;
            if (win < 0 && hasHead[s] && hl[s] != 0) win = s;
        end
        for (int i = 0; i < NUM_SRC; i++) begin
            if (hasHead[i] && (hl[i] == 0 || i == win)) begin
                if (byp[i]) store[i] = 1'b0;
                else begin
                    void'(mData[i].pop_front());
                    void'(mLabel[i].pop_front());
                end
            end
            if (store[i]) begin
                mData[i].push_back(srcData[i*DATA_W +: DATA_W]);
                mLabel[i].push_back(srcLabel[i*LABEL_W +: LABEL_W]);
            end
        end
        expBcen  = (win >= 0);
        expData  = (win >= 0) ? hd[win] : '0;
        expLabel = (win >= 0) ? hl[win] : '0;
        if (win >= 0) mRr = (win + 1) % NUM_SRC;
        expPending = 0;
        for (int i = 0; i < NUM_SRC; i++) expPending += mLabel[i].size();
    endtask

    function automatic logic [NUM_SRC-1:0] modelReady();
        logic [NUM_SRC-1:0] r;
        for (int i = 0; i < NUM_SRC; i++) r[i] = (mLabel[i].size() < DEPTH) && !rst;
        return r;
    endfunction

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic setSrc(input int i, input logic [LABEL_W-1:0] lab, input logic [DATA_W-1:0] dat);
        srcValid[i] = 1'b1;
        srcLabel[i*LABEL_W +: LABEL_W] = lab;
        srcData[i*DATA_W +: DATA_W]    = dat;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        srcValid = '0;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        srcValid = '0;
        step();
        checks++; if (bcen !== 1'b0) begin failures++; $display("FAIL reset_bcen got=%b exp=0", bcen); end
        checks++; if (bcData !== '0) begin failures++; $display("FAIL reset_data got=%h exp=0", bcData); end
        checks++; if (bcLabel !== '0) begin failures++; $display("FAIL reset_label got=%h exp=0", bcLabel); end
        checks++; if (pendingOut !== '0) begin failures++; $display("FAIL reset_pending got=%0d exp=0", pendingOut); end
        checks++; if (srcReady !== 4'b0000) begin failures++; $display("FAIL reset_ready_during got=%b exp=0000", srcReady); end
        rst = 1'b0;
        #1;
        checks++; if (srcReady !== 4'b1111) begin failures++; $display("FAIL reset_ready_after got=%b exp=1111", srcReady); end
    endtask

    task automatic test_single();
        apply_reset();
        setSrc(0, 4'd3, 32'h0000_1234);
        for (int c = 1; c <= 3; c++) begin
            step();
            srcValid = '0;
            checks++; if (bcen !== (c == LAT)) begin failures++; $display("FAIL single_bcen c=%0d got=%b exp=%b", c, bcen, (c == LAT)); end
            checks++; if (bcData !== ((c == LAT) ? 32'h0000_1234 : 32'h0)) begin failures++; $display("FAIL single_data c=%0d got=%h", c, bcData); end
            checks++; if (bcLabel !== ((c == LAT) ? 4'd3 : 4'd0)) begin failures++; $display("FAIL single_label c=%0d got=%h", c, bcLabel); end
            checks++; if (int'(pendingOut) !== ((c < LAT) ? 1 : 0)) begin failures++; $display("FAIL single_pending c=%0d got=%0d", c, pendingOut); end
        end
    endtask

    task automatic test_all_four();
        logic               eb;
        logic [LABEL_W-1:0] el;
        logic [DATA_W-1:0]  ed;
        int                 ep;
        apply_reset();
        for (int i = 0; i < NUM_SRC; i++) setSrc(i, LABEL_W'(i + 1), 32'hC0DE_0000 + i);
        for (int c = 1; c <= LAT + 4; c++) begin
            step();
            srcValid = '0;
            eb = (c >= LAT) && (c <= LAT + 3);
            el = eb ? LABEL_W'(c - LAT + 1) : '0;
            ed = eb ? 32'hC0DE_0000 + (c - LAT) : '0;
            ep = (3 + LAT - c > 0) ? 3 + LAT - c : 0;
            checks++; if (bcen !== eb) begin failures++; $display("FAIL four_bcen c=%0d got=%b exp=%b", c, bcen, eb); end
            checks++; if (bcLabel !== el) begin failures++; $display("FAIL four_label c=%0d got=%0d exp=%0d", c, bcLabel, el); end
            checks++; if (bcData !== ed) begin failures++; $display("FAIL four_data c=%0d got=%h exp=%h", c, bcData, ed); end
            checks++; if (int'(pendingOut) !== ep) begin failures++; $display("FAIL four_pending c=%0d got=%0d exp=%0d", c, pendingOut, ep); end
        end
        // Pointer has wrapped to 0: source 0 must beat source 3.
        setSrc(0, 4'd5, 32'h0000_0005);
        setSrc(3, 4'd6, 32'h0000_0006);
        for (int c = 1; c <= LAT + 1; c++) begin
            step();
            srcValid = '0;
            el = (c == LAT) ? 4'd5 : ((c == LAT + 1) ? 4'd6 : 4'd0);
            checks++; if (bcLabel !== el) begin failures++; $display("FAIL four_rrwrap c=%0d got=%0d exp=%0d", c, bcLabel, el); end
        end
    endtask

    task automatic test_back_to_back();
        logic [LABEL_W-1:0] seq [3];
        logic [LABEL_W-1:0] got [$];
        int sent;
        seq[0] = 4'd5; seq[1] = 4'd6; seq[2] = 4'd7;
        sent = 0;
        apply_reset();
        for (int c = 0; c < 30; c++) begin
            srcValid = '0;
            if (c < 20) begin
                setSrc(0, 4'd1, $urandom);
                setSrc(2, 4'd2, $urandom);
            end
            if (sent < 3) setSrc(1, seq[sent], 32'h5000_0000 + 32'(seq[sent]));
            step();
            if (mAcc[1]) sent++;
            checks++; if (bcen !== expBcen) begin failures++; $display("FAIL b2b_bcen c=%0d got=%b exp=%b", c, bcen, expBcen); end
            checks++; if (bcLabel !== expLabel) begin failures++; $display("FAIL b2b_label c=%0d got=%0d exp=%0d", c, bcLabel, expLabel); end
            checks++; if (bcData !== expData) begin failures++; $display("FAIL b2b_data c=%0d got=%h exp=%h", c, bcData, expData); end
            checks++; if (int'(pendingOut) !== expPending) begin failures++; $display("FAIL b2b_pending c=%0d got=%0d exp=%0d", c, pendingOut, expPending); end
            checks++; if (srcReady !== modelReady()) begin failures++; $display("FAIL b2b_ready c=%0d got=%b exp=%b", c, srcReady, modelReady()); end
            if (bcen && bcLabel >= 4'd5 && bcLabel <= 4'd7) got.push_back(bcLabel);
        end
        srcValid = '0;
        checks++; if (got.size() !== 3) begin failures++; $display("FAIL b2b_count got=%0d exp=3", got.size()); end
        for (int j = 0; j < 3; j++) begin
            checks++;
            if (j >= got.size() || got[j] !== seq[j]) begin
                failures++;
                $display("FAIL b2b_order idx=%0d got=%0d exp=%0d", j, (j < got.size()) ? got[j] : 4'd0, seq[j]);
            end
        end
    endtask

    task automatic test_zero_tag();
        apply_reset();
        setSrc(3, 4'd0, 32'hDEAD_BEEF);
        for (int c = 1; c <= 3; c++) begin
            step();
            srcValid = '0;
            checks++; if (bcen !== 1'b0) begin failures++; $display("FAIL zero_bcen c=%0d got=%b exp=0", c, bcen); end
            checks++; if (int'(pendingOut) !== ((c < LAT) ? 1 : 0)) begin failures++; $display("FAIL zero_pending c=%0d got=%0d", c, pendingOut); end
        end
        setSrc(3, 4'd9, 32'h9999_0009);
        for (int c = 1; c <= LAT + 1; c++) begin
            step();
            srcValid = '0;
            checks++; if (bcen !== (c == LAT)) begin failures++; $display("FAIL zero_next_bcen c=%0d got=%b", c, bcen); end
            checks++; if (bcLabel !== ((c == LAT) ? 4'd9 : 4'd0)) begin failures++; $display("FAIL zero_next_label c=%0d got=%0d", c, bcLabel); end
            checks++; if (bcData !== ((c == LAT) ? 32'h9999_0009 : 32'h0)) begin failures++; $display("FAIL zero_next_data c=%0d got=%h", c, bcData); end
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        for (int i = 0; i < 3; i++) setSrc(i, LABEL_W'(i + 1), $urandom);
        step();
        srcValid = '0;
        checks++; if (int'(pendingOut) !== 1 + LAT) begin failures++; $display("FAIL rmid_buffered got=%0d exp=%0d", pendingOut, 1 + LAT); end
        rst = 1'b1;
        #1;
        checks++; if (srcReady !== 4'b0000) begin failures++; $display("FAIL rmid_ready_during got=%b exp=0000", srcReady); end
        step();
        checks++; if (bcen !== 1'b0) begin failures++; $display("FAIL rmid_bcen got=%b exp=0", bcen); end
        checks++; if (bcLabel !== '0) begin failures++; $display("FAIL rmid_label got=%0d exp=0", bcLabel); end
        checks++; if (pendingOut !== '0) begin failures++; $display("FAIL rmid_pending got=%0d exp=0", pendingOut); end
        rst = 1'b0;
        #1;
        checks++; if (srcReady !== 4'b1111) begin failures++; $display("FAIL rmid_ready_after got=%b exp=1111", srcReady); end
        for (int c = 1; c <= 4; c++) begin
            step();
            checks++; if (bcen !== 1'b0 || bcLabel !== '0) begin failures++; $display("FAIL rmid_stale c=%0d bcen=%b label=%0d exp=0", c, bcen, bcLabel); end
        end
    endtask

    task automatic test_fairness();
        int  alt;
        bit  found;
        alt = 0;
        found = 1'b0;
        apply_reset();
        for (int c = 0; c < 6; c++) begin
            setSrc(2, (alt % 2 == 0) ? 4'd8 : 4'd9, 32'h2000_0000 + alt);
            step();
            if (mAcc[2]) alt++;
            checks++; if (bcLabel !== expLabel) begin failures++; $display("FAIL fair_pre_label c=%0d got=%0d exp=%0d", c, bcLabel, expLabel); end
        end
        setSrc(0, 4'd1, 32'h0000_0F01);
        for (int n = 1; n <= NUM_SRC; n++) begin
            setSrc(2, (alt % 2 == 0) ? 4'd8 : 4'd9, 32'h2000_0000 + alt);
            step();
            srcValid[0] = 1'b0;
            if (mAcc[2]) alt++;
            checks++; if (bcLabel !== expLabel || bcen !== expBcen) begin failures++; $display("FAIL fair_label n=%0d got=%0d/%b exp=%0d/%b", n, bcLabel, bcen, expLabel, expBcen); end
            if (bcen && bcLabel == 4'd1 && bcData == 32'h0000_0F01) found = 1'b1;
        end
        srcValid = '0;
        checks++; if (found !== 1'b1) begin failures++; $display("FAIL fair_bound label1 seen=%b exp=1 within %0d cycles", found, NUM_SRC); end
    endtask

    task automatic test_random();
        apply_reset();
        for (int c = 0; c < 400; c++) begin
            rst      = ($urandom_range(0, 49) == 0);
            srcValid = NUM_SRC'($urandom);
            srcLabel = (NUM_SRC*LABEL_W)'($urandom);
            for (int i = 0; i < NUM_SRC; i++) srcData[i*DATA_W +: DATA_W] = $urandom;
            step();
            checks++; if (bcen !== expBcen) begin failures++; $display("FAIL rand_bcen c=%0d got=%b exp=%b", c, bcen, expBcen); end
            checks++; if (bcLabel !== expLabel) begin failures++; $display("FAIL rand_label c=%0d got=%0d exp=%0d", c, bcLabel, expLabel); end
            checks++; if (bcData !== expData) begin failures++; $display("FAIL rand_data c=%0d got=%h exp=%h", c, bcData, expData); end
            checks++; if (int'(pendingOut) !== expPending) begin failures++; $display("FAIL rand_pending c=%0d got=%0d exp=%0d", c, pendingOut, expPending); end
            checks++; if (srcReady !== modelReady()) begin failures++; $display("FAIL rand_ready c=%0d got=%b exp=%b", c, srcReady, modelReady()); end
        end
        rst = 1'b0;
        srcValid = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_all_four();
        test_back_to_back();
        test_zero_tag();
        test_reset_mid();
        test_fairness();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
